// File: rtl/timing_window_if.sv
// Per-channel start/abort/config bus and strobe/status returns for timing_window_mc.
interface timing_window_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned LAT_W  = 8,
    parameter int unsigned WID_W  = 4
);
    logic [NUM_CH-1:0]       start;
    logic [NUM_CH-1:0]       abort;
    logic [NUM_CH*LAT_W-1:0] cfg_lat;
    logic [NUM_CH*WID_W-1:0] cfg_wid;
    logic [NUM_CH-1:0]       strobe;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH-1:0]       drop;

    modport master (
        output start, abort, cfg_lat, cfg_wid,
        input  strobe, busy, done, drop
    );

    modport slave (
        input  start, abort, cfg_lat, cfg_wid,
        output strobe, busy, done, drop
    );
endinterface

// File: rtl/timing_window_mc.sv
// NUM_CH independent delay/width strobe generators with done, drop,
// abort, retrigger policy and back-to-back window support.
module timing_window_mc #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned LAT_W  = 8,
    parameter int unsigned WID_W  = 4,
    parameter int unsigned RETRIG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    timing_window_if.slave   tw
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_STROBE = 2'd2
    } state_e;

    state_e             state_q   [NUM_CH];
    logic [LAT_W-1:0]   lat_cnt_q [NUM_CH];
    logic [WID_W-1:0]   wid_cnt_q [NUM_CH];
    logic [NUM_CH-1:0]  strobe_q;
    logic [NUM_CH-1:0]  busy_q;
    logic [NUM_CH-1:0]  done_q;
    logic [NUM_CH-1:0]  drop_q;

    logic [LAT_W-1:0]   lat_ld_c  [NUM_CH];
    logic [WID_W-1:0]   wid_ld_c  [NUM_CH];
    logic [NUM_CH-1:0]  lat_zero_c;
    logic [NUM_CH-1:0]  last_c;
    logic [NUM_CH-1:0]  accept_c;

    // Counters load value-1 so the terminal count is 0; a width of 0 behaves as 1.
    always_comb begin
        lat_zero_c = '0;
        last_c     = '0;
        accept_c   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lat_ld_c[i] = '0;
            wid_ld_c[i] = '0;
            if (tw.cfg_lat[i*LAT_W +: LAT_W] != '0)
                lat_ld_c[i] = tw.cfg_lat[i*LAT_W +: LAT_W] - LAT_W'(1);
            if (tw.cfg_wid[i*WID_W +: WID_W] != '0)
                wid_ld_c[i] = tw.cfg_wid[i*WID_W +: WID_W] - WID_W'(1);
            lat_zero_c[i] = (tw.cfg_lat[i*LAT_W +: LAT_W] == '0);
            last_c[i]     = (state_q[i] == S_STROBE) && (wid_cnt_q[i] == '0);
            accept_c[i]   = tw.start[i] &&
                            ((state_q[i] == S_IDLE) || last_c[i] || (RETRIG != 0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]   <= S_IDLE;
                lat_cnt_q[i] <= '0;
                wid_cnt_q[i] <= '0;
            end
            strobe_q <= '0;
            busy_q   <= '0;
            done_q   <= '0;
            drop_q   <= '0;
        end else begin
            done_q <= '0;
            drop_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (tw.abort[i]) begin
                    state_q[i]   <= S_IDLE;
                    lat_cnt_q[i] <= '0;
                    wid_cnt_q[i] <= '0;
                    strobe_q[i]  <= 1'b0;
                    busy_q[i]    <= 1'b0;
                end else if (accept_c[i]) begin
                    state_q[i]   <= lat_zero_c[i] ? S_STROBE : S_DELAY;
                    lat_cnt_q[i] <= lat_ld_c[i];
                    wid_cnt_q[i] <= wid_ld_c[i];
                    strobe_q[i]  <= lat_zero_c[i];
                    busy_q[i]    <= 1'b1;
                    done_q[i]    <= last_c[i];
                end else begin
                    // Only a busy channel can get here with start set.
                    drop_q[i] <= tw.start[i];
                    case (state_q[i])
                        S_DELAY: begin
                            if (lat_cnt_q[i] == '0) begin
                                state_q[i]  <= S_STROBE;
                                strobe_q[i] <= 1'b1;
                            end else begin
                                lat_cnt_q[i] <= lat_cnt_q[i] - LAT_W'(1);
                            end
                        end
                        S_STROBE: begin
                            if (wid_cnt_q[i] == '0) begin
                                state_q[i]  <= S_IDLE;
                                strobe_q[i] <= 1'b0;
                                busy_q[i]   <= 1'b0;
                                done_q[i]   <= 1'b1;
                            end else begin
                                wid_cnt_q[i] <= wid_cnt_q[i] - WID_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign tw.strobe = strobe_q;
    assign tw.busy   = busy_q;
    assign tw.done   = done_q;
    assign tw.drop   = drop_q;
endmodule

// File: tb/tb_timing_window_mc.sv
// Directed bench for timing_window_mc: per-edge vector table plus retrigger,
// reset, concurrency and config-stability sequences.
module tb_timing_window_mc;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned LAT_W  = 8;
    localparam int unsigned WID_W  = 4;

    logic clk;
    logic rst_n;

    timing_window_if #(.NUM_CH(NUM_CH), .LAT_W(LAT_W), .WID_W(WID_W)) if0 ();
    timing_window_if #(.NUM_CH(NUM_CH), .LAT_W(LAT_W), .WID_W(WID_W)) if1 ();

    timing_window_mc #(.NUM_CH(NUM_CH), .LAT_W(LAT_W), .WID_W(WID_W), .RETRIG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tw(if0)
    );
    timing_window_mc #(.NUM_CH(NUM_CH), .LAT_W(LAT_W), .WID_W(WID_W), .RETRIG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tw(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       ab;
        logic [7:0] lat;
        logic [3:0] wid;
        logic       e_str;
        logic       e_busy;
        logic       e_done;
        logic       e_drop;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt;
    int   total_cnt;

    task automatic add(input int st, input int ab, input int lat, input int wid,
                       input int s, input int b, input int d, input int dr);
        vec_t v;
        v.st = 1'(st);  v.ab = 1'(ab);
        v.lat = 8'(lat); v.wid = 4'(wid);
        v.e_str = 1'(s); v.e_busy = 1'(b); v.e_done = 1'(d); v.e_drop = 1'(dr);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic idle_inputs();
        if0.start = '0; if0.abort = '0; if0.cfg_lat = '0; if0.cfg_wid = '0;
        if1.start = '0; if1.abort = '0; if1.cfg_lat = '0; if1.cfg_wid = '0;
    endtask

    int unsigned lat_a [NUM_CH];
    int unsigned wid_a [NUM_CH];
    int unsigned wv;
    logic [3:0]  e_s, e_b, e_d;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        idle_inputs();

        // Single window L=3 W=2; cfg changes after start must be ignored.
        add(1,0,3,2, 0,1,0,0);
        add(0,0,7,9, 0,1,0,0);
        add(0,0,7,9, 0,1,0,0);
        add(0,0,7,9, 1,1,0,0);
        add(0,0,7,9, 1,1,0,0);
        add(0,0,7,9, 0,0,1,0);
        add(0,0,0,0, 0,0,0,0);
        // L=0 W=0
        add(1,0,0,0, 1,1,0,0);
        add(0,0,0,0, 0,0,1,0);
        add(0,0,0,0, 0,0,0,0);
        // Start while busy, RETRIG=0: drop, window unchanged.
        add(1,0,5,1, 0,1,0,0);
        add(0,0,5,1, 0,1,0,0);
        add(1,0,2,3, 0,1,0,1);
        add(0,0,2,3, 0,1,0,0);
        add(0,0,2,3, 0,1,0,0);
        add(0,0,2,3, 1,1,0,0);
        add(0,0,2,3, 0,0,1,0);
        // Back-to-back L=0 W=3, second start in the final strobe cycle.
        add(1,0,0,3, 1,1,0,0);
        add(0,0,0,3, 1,1,0,0);
        add(0,0,0,3, 1,1,0,0);
        add(1,0,0,3, 1,1,1,0);
        add(0,0,0,3, 1,1,0,0);
        add(0,0,0,3, 1,1,0,0);
        add(0,0,0,3, 0,0,1,0);
        // Abort during DELAY with a simultaneous start.
        add(1,0,4,2, 0,1,0,0);
        add(0,0,4,2, 0,1,0,0);
        add(1,1,4,2, 0,0,0,0);
        for (int i = 0; i < 5; i++) add(0,0,4,2, 0,0,0,0);

        repeat (3) @(posedge clk);
        #1;
        check("reset strobe0", if0.strobe, 4'b0);
        check("reset busy0",   if0.busy,   4'b0);
        check("reset done0",   if0.done,   4'b0);
        check("reset drop0",   if0.drop,   4'b0);
        check("reset busy1",   if1.busy,   4'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if0.start   = {3'b0, vecs[i].st};
            if0.abort   = {3'b0, vecs[i].ab};
            if0.cfg_lat = {24'h0, vecs[i].lat};
            if0.cfg_wid = {12'h0, vecs[i].wid};
            @(posedge clk);
            #1;
            check($sformatf("row%0d strobe", i), if0.strobe, {3'b0, vecs[i].e_str});
            check($sformatf("row%0d busy", i),   if0.busy,   {3'b0, vecs[i].e_busy});
            check($sformatf("row%0d done", i),   if0.done,   {3'b0, vecs[i].e_done});
            check($sformatf("row%0d drop", i),   if0.drop,   {3'b0, vecs[i].e_drop});
        end
        idle_inputs();

        // RETRIG=1: L=5 W=1, restart at E2 -> strobe after E7, single done after E8.
        for (int k = 0; k <= 10; k++) begin
            if1.start   = (k == 0 || k == 2) ? 4'b0001 : 4'b0000;
            if1.cfg_lat = 32'd5;
            if1.cfg_wid = 16'd1;
            @(posedge clk);
            #1;
            check($sformatf("retrig k%0d strobe", k), if1.strobe, {3'b0, k == 7});
            check($sformatf("retrig k%0d busy", k),   if1.busy,   {3'b0, k <= 7});
            check($sformatf("retrig k%0d done", k),   if1.done,   {3'b0, k == 8});
            check($sformatf("retrig k%0d drop", k),   if1.drop,   4'b0);
        end
        idle_inputs();

        // Asynchronous reset mid-STROBE.
        if0.start = 4'b0001; if0.cfg_lat = 32'd0; if0.cfg_wid = 16'd8;
        @(posedge clk);
        #1;
        if0.start = '0;
        @(posedge clk);
        #1;
        check("pre-reset strobe", if0.strobe, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset strobe", if0.strobe, 4'b0);
        check("async reset busy",   if0.busy,   4'b0);
        check("async reset done",   if0.done,   4'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset busy", if0.busy, 4'b0);
        check("post-reset done", if0.done, 4'b0);

        // All channels at once, including max latency and width.
        lat_a = '{255, 0, 7, 1};
        wid_a = '{15, 0, 4, 15};
        for (int c = 0; c < NUM_CH; c++) begin
            if0.cfg_lat[c*LAT_W +: LAT_W] = 8'(lat_a[c]);
            if0.cfg_wid[c*WID_W +: WID_W] = 4'(wid_a[c]);
        end
        if0.start = 4'b1111;
        for (int k = 0; k <= 272; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                if0.start   = '0;
                if0.cfg_lat = 32'h0302_0104;
                if0.cfg_wid = 16'h2361;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                wv = (wid_a[c] == 0) ? 1 : wid_a[c];
                e_s[c] = (k >= int'(lat_a[c])) && (k <= int'(lat_a[c] + wv - 1));
                e_b[c] = (k <= int'(lat_a[c] + wv - 1));
                e_d[c] = (k == int'(lat_a[c] + wv));
            end
            check($sformatf("conc k%0d strobe", k), if0.strobe, e_s);
            check($sformatf("conc k%0d busy", k),   if0.busy,   e_b);
            check($sformatf("conc k%0d done", k),   if0.done,   e_d);
        end
        check("conc drop", if0.drop, 4'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/timing_window_mc.md
Name: timing_window_mc

Overview:
- Multi-channel successor to the single-channel latency/strobe generator.
- NUM_CH independent channels. Each turns a one-cycle start into a strobe window of runtime-programmable delay and width.
- Adds completion pulse, drop/retrigger policy, per-channel abort, and back-to-back windows.
- Used by pipeline control to time sample/enable windows relative to issue events.

Parameters:
- NUM_CH, 4, number of independent channels.
- LAT_W, 8, width of per-channel latency field; latency range 0..2^LAT_W-1 cycles.
- WID_W, 4, width of per-channel strobe-width field; width range 1..2^WID_W-1 cycles; a value of 0 is treated as 1.
- RETRIG, 0, start-while-busy policy: 0 = ignore the start and pulse drop; 1 = restart the window with the new config.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  NUM_CH  per-channel start pulse.
- abort  input  NUM_CH  per-channel abort; returns the channel to IDLE.
- cfg_lat  input  NUM_CH*LAT_W  per-channel latency; channel i occupies bits [i*LAT_W +: LAT_W].
- cfg_wid  input  NUM_CH*WID_W  per-channel width; channel i occupies bits [i*WID_W +: WID_W].
- strobe  output  NUM_CH  window output.
- busy  output  NUM_CH  channel not IDLE.
- done  output  NUM_CH  one-cycle pulse on normal window completion.
- drop  output  NUM_CH  one-cycle pulse when a start is ignored.

Behaviour:
- Reset: every channel in IDLE, counters 0. strobe, busy, done and drop all 0 (registered outputs; strobe may be decoded from state).
- Per-channel FSM: IDLE, DELAY, STROBE. Channels are fully independent; no shared state.
- Config capture: cfg_lat[i] and cfg_wid[i] are latched on the edge that accepts start[i]. Later config changes do not affect a window in flight.
- Timing, start accepted at edge E0 with latency L and width W:
  - strobe is high in the cycles following edges E_L .. E_{L+W-1}.
  - L=0: strobe is high in the cycle right after E0 (FSM enters STROBE directly).
  - busy is high from after E0 until after E_{L+W}.
  - done pulses for one cycle after E_{L+W}, coincident with strobe falling.
- Transitions, evaluated per edge in this priority order:
  - abort: any state -> IDLE. No done. Any simultaneous start is discarded without a drop pulse.
  - start in IDLE: -> DELAY (L>0) or STROBE (L=0).
  - start in the final STROBE cycle (width count at last): accepted as a back-to-back window, regardless of RETRIG. done still pulses for the finishing window; the new window's strobe may be contiguous with the old one when L=0.
  - start in any other busy cycle, RETRIG=0: ignored; drop pulses for one cycle; the window continues unchanged.
  - start in any other busy cycle, RETRIG=1: reload config and restart from E0 semantics; no done for the abandoned window; no drop.
  - DELAY: latency count reaches terminal -> STROBE.
  - STROBE: width count reaches terminal with no start -> IDLE with done.
- Arithmetic: counters are LAT_W and WID_W bits wide and count down with no wrap. Maximum latency and width values must work exactly (no off-by-one at 2^N-1).
- Asynchronous reset mid-window: immediate return to IDLE, all outputs 0, no done.

Test Plan:
- Single window: ch0 L=3 W=2, start at E0 -> strobe[0] high after E3 and E4; done[0] after E5; busy[0] high after E0..E4; other channels stay quiet.
- Zero latency and zero width: L=0 W=0 -> strobe high only after E0 (W treated as 1); done after E1.
- Retrigger policy with L=5 W=1 and a second start at E2: RETRIG=0 -> drop after E2, strobe after E5; RETRIG=1 -> no drop, strobe after E7, exactly one done after E8.
- Back-to-back: L=0 W=3, second start during the final strobe cycle -> strobe continuously high for 6 cycles; done pulses twice; no drop.
- Abort and reset: abort during DELAY -> IDLE next edge, no strobe, no done. rst_n asserted mid-STROBE -> strobe and busy drop immediately.
- Concurrency and bounds: all NUM_CH channels started in the same cycle with distinct L/W, including max L=255 and W=15 -> each window is exact and independent. Changing cfg after start leaves in-flight windows unaffected.
